switch_debounce_port: RTL

- Switch peripheral directly upstream of the I/O read mux; it produces the 16-bit switch read data that the mux forwards to memorio when the switch chip select and I/O read are active.
- Synchronises and debounces 16 raw board switches and holds a stable switch-value register.
- Holds a sticky change-flag register, cleared on read, and a level interrupt request derived from it.

---
 rtl/switch_debounce_port.sv | 117 +++++++++++
 1 files changed

// File: rtl/switch_debounce_port.sv
// rtl/switch_debounce_port.sv - synchronised, debounced 16-bit switch port with sticky change flags
//
// Ports:
//   clock        system clock, all state updates on the rising edge
//   reset        synchronous active-high reset
//   switchctrl   switch chip select from the memorio address decode
//   ior          I/O read strobe
//   ioaddr       2'b00 reads the stable value, 2'b10 reads (and clears) the change flags
//   switch_raw   asynchronous board switch levels
//   switchrdata  combinational read data towards the I/O read mux
//   sw_irq       level interrupt, high while any change flag is set
module switch_debounce_port #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned STABLE_N = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        switchctrl,
  input  logic        ior,
  input  logic [1:0]  ioaddr,
  input  logic [15:0] switch_raw,
  output logic [15:0] switchrdata,
  output logic        sw_irq
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [15:0]               sync1_q, sync1_d;
  logic [15:0]               sync2_q, sync2_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [15:0][STABLE_N-1:0] hist_q, hist_d;
  logic [15:0]               stable_q, stable_d;
  logic [15:0]               flag_q, flag_d;
  logic [15:0]               flag_set;
  logic                      tick;
  logic                      rd_sel;
  logic                      flag_rd;

  // Two-flop synchroniser; sync2_q is the only copy of the switches the
  // debouncer ever looks at.
  always_comb begin
    sync1_d = switch_raw;
    sync2_d = sync1_q;
  end

  // Sample prescaler: tick is high for the single cycle in which the count
  // sits at its last value, so the history shifts on the wrapping edge.
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // Per-bit debounce. The acceptance test looks at the history including the
  // sample being shifted in on this edge, so a level is taken after exactly
  // STABLE_N agreeing samples.
  always_comb begin
    logic [STABLE_N-1:0] h;
    hist_d   = hist_q;
    stable_d = stable_q;
    flag_set = '0;
    h        = '0;
    if (tick) begin
      for (int i = 0; i < 16; i++) begin
        h         = {hist_q[i][STABLE_N-2:0], sync2_q[i]};
        hist_d[i] = h;
        if ((&h) && !stable_q[i]) begin
          stable_d[i] = 1'b1;
          flag_set[i] = 1'b1;
        end else if (!(|h) && stable_q[i]) begin
          stable_d[i] = 1'b0;
          flag_set[i] = 1'b1;
        end
      end
    end
  end

  // Flag register: a flag read clears everything except bits being set on
  // the same edge, so a change accepted during the read is not lost.
  always_comb begin
    rd_sel  = switchctrl & ior;
    flag_rd = rd_sel && (ioaddr == 2'b10);
    flag_d  = (flag_rd ? 16'h0000 : flag_q) | flag_set;
  end

  always_comb begin
    switchrdata = 16'h0000;
    if (rd_sel) begin
      case (ioaddr)
        2'b00:   switchrdata = stable_q;
        2'b10:   switchrdata = flag_q;
        default: switchrdata = 16'h0000;
      endcase
    end
  end

  assign sw_irq = |flag_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cnt_q    <= '0;
      hist_q   <= '0;
      stable_q <= '0;
      flag_q   <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      hist_q   <= hist_d;
      stable_q <= stable_d;
      flag_q   <= flag_d;
    end
  end

endmodule
